// File: rtl/pfcu_pkg.sv
// Shared definitions for the program-flow control unit.
//   PFCU_CLASS : inst[15:14] value that selects a PFCU instruction
//   pfcu_op_e  : inst[13:12] opcode decode
//   ERR_OVF / ERR_UNF : bit positions inside stk_err
package pfcu_pkg;

  localparam logic [1:0] PFCU_CLASS = 2'b10;

  typedef enum logic [1:0] {
    OP_JMP  = 2'b00,
    OP_JIZ  = 2'b01,
    OP_CALL = 2'b10,
    OP_RET  = 2'b11
  } pfcu_op_e;

  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_UNF = 1;

endpackage

// File: rtl/pfcu_ret_stack.sv
// Return-address LIFO with STK_DEPTH entries of ADDR_W bits.
// Ports:
//   clk, rst_n  : clock, async active-low reset (resets the stack pointer only)
//   push, pop   : mutually exclusive; caller guarantees no push when full / pop when empty
//   clr         : synchronous flush; a same-cycle push lands in slot 0
//   push_data   : value written on push
//   top_data    : entry at sp-1 (meaningful only when not empty)
//   full, empty : decoded from the registered stack pointer
module pfcu_ret_stack #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned STK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              clr,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned IdxW = $clog2(STK_DEPTH);
  localparam int unsigned SpW  = IdxW + 1;

  logic [SpW-1:0]    sp_q, sp_d;
  logic [IdxW-1:0]   wr_idx, rd_idx;
  logic [ADDR_W-1:0] mem_q [STK_DEPTH];

  always_comb begin
    sp_d   = sp_q;
    wr_idx = sp_q[IdxW-1:0];
    if (clr) begin
      // Flush wins; a concurrent push restarts the stack at slot 0.
      sp_d   = push ? SpW'(1) : '0;
      wr_idx = '0;
    end else if (push) begin
      sp_d = sp_q + SpW'(1);
    end else if (pop) begin
      sp_d = sp_q - SpW'(1);
    end
  end

  assign rd_idx   = IdxW'(sp_q - SpW'(1));
  assign top_data = mem_q[rd_idx];
  assign full     = (sp_q == SpW'(STK_DEPTH));
  assign empty    = (sp_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pfcu_call_stack_ctrl.sv
// Program-flow control unit: decodes JMP/JIZ/CALL/RET and drives a registered
// new-PC value with a one-cycle write strobe; CALL/RET use a hardware return stack.
// Build option: define PFCU_STK_TRAP_EN to redirect stack overflow/underflow to TRAP_VEC.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   pfcu_en      : unit enable
//   inst_vld     : inst valid this cycle
//   inst         : 16-bit instruction word
//   alu_status   : ALU flags (bit ZERO_BIT tested by JIZ)
//   pc_cur       : address of the presented instruction
//   stk_clr      : synchronous return-stack flush (also clears stk_err)
//   pc_inp       : registered new PC
//   pc_we        : registered one-cycle PC write strobe
//   stk_empty    : stack empty
//   stk_full     : stack full
//   stk_err      : sticky {underflow, overflow}
module pfcu_call_stack_ctrl
  import pfcu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned STK_DEPTH = 8,
  parameter int unsigned ZERO_BIT  = 0,
  parameter int unsigned TRAP_VEC  = 'hFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pfcu_en,
  input  logic              inst_vld,
  input  logic [15:0]       inst,
  input  logic [7:0]        alu_status,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              stk_clr,
  output logic [ADDR_W-1:0] pc_inp,
  output logic              pc_we,
  output logic              stk_empty,
  output logic              stk_full,
  output logic [1:0]        stk_err
);

`ifdef PFCU_STK_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] TrapPc = ADDR_W'(TRAP_VEC);

  logic              accept;
  pfcu_op_e          op;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] top_data;
  logic              push, pop, ovf, unf;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              we_q, we_d;
  logic [1:0]        err_q, err_d;
  logic              unused_bits;

  assign accept      = pfcu_en && inst_vld && (inst[15:14] == PFCU_CLASS);
  assign op          = pfcu_op_e'(inst[13:12]);
  assign k           = inst[ADDR_W-1:0];
  assign unused_bits = ^{alu_status, inst};

  always_comb begin
    pc_d = pc_q;
    we_d = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    ovf  = 1'b0;
    unf  = 1'b0;
    if (accept) begin
      unique case (op)
        OP_JMP: begin
          we_d = 1'b1;
          pc_d = k;
        end
        OP_JIZ: begin
          if (alu_status[ZERO_BIT]) begin
            we_d = 1'b1;
            pc_d = k;
          end
        end
        OP_CALL: begin
          // A same-cycle flush empties the stack, so the push is always legal then.
          we_d = 1'b1;
          if (stk_full && !stk_clr) begin
            ovf  = 1'b1;
            pc_d = TrapEn ? TrapPc : k;
          end else begin
            push = 1'b1;
            pc_d = k;
          end
        end
        OP_RET: begin
          if (stk_empty || stk_clr) begin
            unf = 1'b1;
            if (TrapEn) begin
              we_d = 1'b1;
              pc_d = TrapPc;
            end
          end else begin
            pop  = 1'b1;
            we_d = 1'b1;
            pc_d = top_data;
          end
        end
      endcase
    end
  end

  always_comb begin
    err_d          = stk_clr ? 2'b00 : err_q;
    err_d[ERR_OVF] = err_d[ERR_OVF] | ovf;
    err_d[ERR_UNF] = err_d[ERR_UNF] | unf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      we_q  <= 1'b0;
      err_q <= 2'b00;
    end else begin
      pc_q  <= pc_d;
      we_q  <= we_d;
      err_q <= err_d;
    end
  end

  pfcu_ret_stack #(
    .ADDR_W   (ADDR_W),
    .STK_DEPTH(STK_DEPTH)
  ) u_ret_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .clr      (stk_clr),
    .push_data(pc_cur + ADDR_W'(1)),
    .top_data (top_data),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  assign pc_inp  = pc_q;
  assign pc_we   = we_q;
  assign stk_err = err_q;

endmodule

// File: tb/tb_pfcu_call_stack_ctrl.sv
// Bench for pfcu_call_stack_ctrl (ADDR_W=12, STK_DEPTH=8, ZERO_BIT=0, TRAP_VEC=0xFFF).
// A queue-based reference model is compared on every falling edge; directed
// scenarios add hand-computed literal checks.
module tb_pfcu_call_stack_ctrl;

  localparam int DEPTH = 8;
`ifdef PFCU_STK_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pfcu_en = 1'b0;
  logic        inst_vld = 1'b0;
  logic [15:0] inst = '0;
  logic [7:0]  alu_status = '0;
  logic [11:0] pc_cur = '0;
  logic        stk_clr = 1'b0;
  logic [11:0] pc_inp;
  logic        pc_we;
  logic        stk_empty;
  logic        stk_full;
  logic [1:0]  stk_err;

  int n_checks = 0;
  int n_fail   = 0;

  pfcu_call_stack_ctrl #(
    .ADDR_W   (12),
    .STK_DEPTH(DEPTH),
    .ZERO_BIT (0),
    .TRAP_VEC ('hFFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pfcu_en   (pfcu_en),
    .inst_vld  (inst_vld),
    .inst      (inst),
    .alu_status(alu_status),
    .pc_cur    (pc_cur),
    .stk_clr   (stk_clr),
    .pc_inp    (pc_inp),
    .pc_we     (pc_we),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
    .stk_err   (stk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: return stack as a queue, outputs as "what the next cycle shows".
  logic [11:0] m_stack[$];
  logic        m_we;
  logic [11:0] m_pc;
  logic [1:0]  m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stack.delete();
      m_we  = 1'b0;
      m_pc  = 12'h000;
      m_err = 2'b00;
    end else begin
      m_we = 1'b0;
      if (stk_clr) begin
        m_stack.delete();
        m_err = 2'b00;
      end
      if (pfcu_en && inst_vld && inst[15:14] == 2'b10) begin
        case (inst[13:12])
          2'b00: begin m_we = 1'b1; m_pc = inst[11:0]; end
          2'b01: if (alu_status[0]) begin m_we = 1'b1; m_pc = inst[11:0]; end
          2'b10: begin
            m_we = 1'b1;
            if (m_stack.size() == DEPTH) begin
              m_err[0] = 1'b1;
              m_pc = TRAP ? 12'hFFF : inst[11:0];
            end else begin
              m_stack.push_back(pc_cur + 12'h001);
              m_pc = inst[11:0];
            end
          end
          default: begin
            if (m_stack.size() == 0) begin
              m_err[1] = 1'b1;
              if (TRAP) begin m_we = 1'b1; m_pc = 12'hFFF; end
            end else begin
              m_we = 1'b1;
              m_pc = m_stack.pop_back();
            end
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("m.pc_we", {31'b0, pc_we}, {31'b0, m_we});
    if (m_we) chk("m.pc_inp", {20'b0, pc_inp}, {20'b0, m_pc});
    chk("m.stk_empty", {31'b0, stk_empty}, {31'b0, (m_stack.size() == 0)});
    chk("m.stk_full", {31'b0, stk_full}, {31'b0, (m_stack.size() == DEPTH)});
    chk("m.stk_err", {30'b0, stk_err}, {30'b0, m_err});
  end

  function automatic logic [15:0] enc(input logic [1:0] op, input logic [11:0] k);
    return {2'b10, op, k};
  endfunction

  // Present one instruction for one cycle; returns 1 time unit after the capturing edge.
  task automatic step(input logic en, input logic vld, input logic [15:0] ins,
                      input logic [7:0] st, input logic [11:0] pc, input logic clr);
    pfcu_en = en; inst_vld = vld; inst = ins; alu_status = st; pc_cur = pc; stk_clr = clr;
    @(posedge clk);
    #1;
    pfcu_en = 1'b1; inst_vld = 1'b0; stk_clr = 1'b0; alu_status = '0;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 16'h0000, 8'h00, 12'h000, 1'b0);
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pc_inp", {20'b0, pc_inp}, 32'h0);
    chk("rst.pc_we", {31'b0, pc_we}, 32'h0);
    chk("rst.empty", {31'b0, stk_empty}, 32'h1);
    chk("rst.full", {31'b0, stk_full}, 32'h0);
    chk("rst.err", {30'b0, stk_err}, 32'h0);
    rst_n = 1'b1;
    idle();

    // JMP
    step(1'b1, 1'b1, enc(2'b00, 12'h123), 8'h00, 12'h005, 1'b0);
    chk("jmp.we", {31'b0, pc_we}, 32'h1);
    chk("jmp.pc", {20'b0, pc_inp}, 32'h123);
    idle();
    chk("jmp.pulse", {31'b0, pc_we}, 32'h0);

    // JIZ taken / not taken
    step(1'b1, 1'b1, enc(2'b01, 12'h040), 8'h01, 12'h006, 1'b0);
    chk("jiz1.we", {31'b0, pc_we}, 32'h1);
    chk("jiz1.pc", {20'b0, pc_inp}, 32'h040);
    step(1'b1, 1'b1, enc(2'b01, 12'h040), 8'h00, 12'h007, 1'b0);
    chk("jiz0.we", {31'b0, pc_we}, 32'h0);

    // Nested CALL / RET
    step(1'b1, 1'b1, enc(2'b10, 12'h100), 8'h00, 12'h010, 1'b0);
    step(1'b1, 1'b1, enc(2'b10, 12'h200), 8'h00, 12'h020, 1'b0);
    step(1'b1, 1'b1, enc(2'b10, 12'h300), 8'h00, 12'h030, 1'b0);
    chk("call3.pc", {20'b0, pc_inp}, 32'h300);
    step(1'b1, 1'b1, enc(2'b11, 12'hABC), 8'h00, 12'h300, 1'b0);
    chk("ret1.pc", {20'b0, pc_inp}, 32'h031);
    step(1'b1, 1'b1, enc(2'b11, 12'h000), 8'h00, 12'h031, 1'b0);
    chk("ret2.pc", {20'b0, pc_inp}, 32'h021);
    step(1'b1, 1'b1, enc(2'b11, 12'h000), 8'h00, 12'h021, 1'b0);
    chk("ret3.pc", {20'b0, pc_inp}, 32'h011);
    chk("ret3.empty", {31'b0, stk_empty}, 32'h1);

    // Fill, then overflow
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, enc(2'b10, 12'h200 + 12'(i)), 8'h00, 12'h100 + 12'(i), 1'b0);
      if (i == 7) chk("fill8.full", {31'b0, stk_full}, 32'h1);
    end
    chk("ovf.we", {31'b0, pc_we}, 32'h1);
    chk("ovf.pc", {20'b0, pc_inp}, TRAP ? 32'hFFF : 32'h208);
    chk("ovf.err", {30'b0, stk_err}, 32'h1);
    chk("ovf.full", {31'b0, stk_full}, 32'h1);
    step(1'b1, 1'b1, enc(2'b11, 12'h000), 8'h00, 12'h208, 1'b0);
    chk("ovf.ret", {20'b0, pc_inp}, 32'h108);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, enc(2'b11, 12'h000), 8'h00, 12'h000, 1'b0);
    chk("drain.pc", {20'b0, pc_inp}, 32'h101);
    chk("drain.empty", {31'b0, stk_empty}, 32'h1);

    // Underflow, then clear + CALL at 0xFFF
    step(1'b1, 1'b0, 16'h0000, 8'h00, 12'h000, 1'b1);
    chk("clr.err", {30'b0, stk_err}, 32'h0);
    step(1'b1, 1'b1, enc(2'b11, 12'h000), 8'h00, 12'h050, 1'b0);
    chk("unf.we", {31'b0, pc_we}, TRAP ? 32'h1 : 32'h0);
    chk("unf.err", {30'b0, stk_err}, 32'h2);
    step(1'b1, 1'b1, enc(2'b10, 12'h055), 8'h00, 12'hFFF, 1'b1);
    chk("clrcall.err", {30'b0, stk_err}, 32'h0);
    chk("clrcall.empty", {31'b0, stk_empty}, 32'h0);
    chk("clrcall.pc", {20'b0, pc_inp}, 32'h055);
    step(1'b1, 1'b1, enc(2'b11, 12'h000), 8'h00, 12'h055, 1'b0);
    chk("wrap.we", {31'b0, pc_we}, 32'h1);
    chk("wrap.pc", {20'b0, pc_inp}, 32'h000);
    chk("wrap.empty", {31'b0, stk_empty}, 32'h1);

    // RET with same-cycle clear is an underflow
    step(1'b1, 1'b1, enc(2'b10, 12'h077), 8'h00, 12'h070, 1'b0);
    step(1'b1, 1'b1, enc(2'b11, 12'h000), 8'h00, 12'h077, 1'b1);
    chk("clrret.err", {30'b0, stk_err}, 32'h2);
    chk("clrret.empty", {31'b0, stk_empty}, 32'h1);

    // Ignored instructions
    step(1'b0, 1'b1, enc(2'b00, 12'h3C3), 8'h01, 12'h080, 1'b0);
    chk("dis.we", {31'b0, pc_we}, 32'h0);
    step(1'b0, 1'b1, enc(2'b10, 12'h3C3), 8'h01, 12'h081, 1'b0);
    chk("dis.empty", {31'b0, stk_empty}, 32'h1);
    step(1'b1, 1'b1, {2'b01, 2'b00, 12'h3C3}, 8'h01, 12'h082, 1'b0);
    chk("cls.we", {31'b0, pc_we}, 32'h0);
    step(1'b1, 1'b1, {2'b11, 2'b10, 12'h3C3}, 8'h01, 12'h083, 1'b0);
    chk("cls.empty", {31'b0, stk_empty}, 32'h1);

    // Async reset kills an in-flight strobe
    step(1'b1, 1'b1, enc(2'b10, 12'h0A0), 8'h00, 12'h090, 1'b0);
    step(1'b1, 1'b1, enc(2'b00, 12'h3AB), 8'h00, 12'h0A0, 1'b0);
    chk("pre.we", {31'b0, pc_we}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.we", {31'b0, pc_we}, 32'h0);
    chk("arst.empty", {31'b0, stk_empty}, 32'h1);
    #1 rst_n = 1'b1;
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
